// File: rtl/instr_fetch_unit.sv
// Single-stage instruction fetch with IF/ID pipeline register, redirect/stall handling and halt detection.
// Optional performance counters are enabled by defining IFU_PERF_COUNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
`ifdef IFU_PERF_COUNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count,
`endif
    output logic        halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_plus4_nxt;
    logic        w_valid_nxt;
    logic        w_load_fetch;
    logic        w_load_bubble;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = r_pc + 32'd4;

    // Next-state selection: jump beats branch beats stall beats normal fetch; HALTED holds everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc_plus4_nxt = r_pc_plus4;
        w_valid_nxt    = r_valid;
        w_load_fetch   = 1'b0;
        w_load_bubble  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (jump) begin
                    w_pc_nxt       = {jump_target[31:2], 2'b00};
                    w_instr_nxt    = 32'h0000_0000;
                    w_pc_plus4_nxt = 32'h0000_0000;
                    w_valid_nxt    = 1'b0;
                    w_load_bubble  = 1'b1;
                end else if (branch_taken) begin
                    w_pc_nxt       = {branch_target[31:2], 2'b00};
                    w_instr_nxt    = 32'h0000_0000;
                    w_pc_plus4_nxt = 32'h0000_0000;
                    w_valid_nxt    = 1'b0;
                    w_load_bubble  = 1'b1;
                end else if (stall) begin
                    w_pc_nxt       = r_pc;
                end else if (imem_data == HALT_WORD) begin
                    // Halt word is swallowed: PC stays on it and a bubble goes downstream.
                    w_state_nxt    = ST_HALTED;
                    w_instr_nxt    = 32'h0000_0000;
                    w_pc_plus4_nxt = 32'h0000_0000;
                    w_valid_nxt    = 1'b0;
                    w_load_bubble  = 1'b1;
                end else begin
                    w_pc_nxt       = w_pc_inc;
                    w_instr_nxt    = imem_data;
                    w_pc_plus4_nxt = w_pc_inc;
                    w_valid_nxt    = 1'b1;
                    w_load_fetch   = 1'b1;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // PC, FSM state and IF/ID pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC_ALIGNED;
            r_instr    <= 32'h0000_0000;
            r_pc_plus4 <= 32'h0000_0000;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc_plus4 <= w_pc_plus4_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

`ifdef IFU_PERF_COUNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    // Fetch/bubble counters; load strobes are only raised in RUN, so they freeze in HALTED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count  <= 32'h0000_0000;
            r_bubble_count <= 32'h0000_0000;
        end else begin
            if (w_load_fetch) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                r_fetch_count <= r_fetch_count;
            end
            if (w_load_bubble) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end else begin
                r_bubble_count <= r_bubble_count;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;
`else
    logic w_unused_strobes;
    assign w_unused_strobes = w_load_fetch ^ w_load_bubble;
`endif

    assign imem_addr         = r_pc;
    assign if_id_instruction = r_instr;
    assign if_id_pc_plus4    = r_pc_plus4;
    assign if_id_valid       = r_valid;
    assign halted            = (r_state == ST_HALTED);

endmodule
